// File: rtl/ioblock_cfg_pkg.sv
// Shared types and constants for the I/O block configuration controller.
// Config word layout: [1:0] TSMUX code, [2] DORREG.
package ioblock_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] TSMUX_HIZ   = 2'b00;
  localparam logic [1:0] TSMUX_TSCTL = 2'b01;
  localparam logic [1:0] TSMUX_DRV   = 2'b11;

  localparam int CFG_W          = 3;
  localparam int CFG_TSMUX_LSB  = 0;
  localparam int CFG_TSMUX_W    = 2;
  localparam int CFG_DORREG_BIT = 2;

endpackage

// File: rtl/ioblock_cfg_shadow.sv
// NUM_IOB x 3-bit shadow register file: one indexed write port, all
// entries visible in parallel for the atomic commit.
import ioblock_cfg_pkg::*;

module ioblock_cfg_shadow #(
  parameter int NUM_IOB = 8,
  parameter int CNT_W   = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [CNT_W-1:0]           waddr,
  input  logic [CFG_W-1:0]           wdata,
  output logic [CFG_W*NUM_IOB-1:0]   rdata
);

  logic [CFG_W*NUM_IOB-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      for (int k = 0; k < NUM_IOB; k++) begin
        if (we && (waddr == CNT_W'(k))) mem_q[CFG_W*k +: CFG_W] <= wdata;
      end
    end
  end

  assign rdata = mem_q;

endmodule

// File: rtl/ioblock_cfg_ctrl.sv
// Framed configuration loader with atomic commit to the live TSMUX/DORREG buses.
// Optional per-word parity check enabled by defining IOCFG_PARITY_EN.
import ioblock_cfg_pkg::*;

module ioblock_cfg_ctrl #(
  parameter int NUM_IOB = 8,
  parameter int CNT_W   = 6
) (
  input  logic                   IOCLK,
  input  logic                   RST,
  input  logic                   CFG_START,
  input  logic                   CFG_ABORT,
  input  logic                   CFG_VALID,
  output logic                   CFG_READY,
  input  logic [2:0]             CFG_DATA,
  input  logic                   CFG_PAR,
  output logic [2*NUM_IOB-1:0]   TSMUX_OUT,
  output logic [NUM_IOB-1:0]     DORREG_OUT,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR,
  output logic [CNT_W-1:0]       LOAD_CNT,
  output state_t                 CFG_STATE
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_IOB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_IOB - 1);

  state_t state_q, state_d;
  logic   cfg_ready, wr_en, cnt_clr, err_set, err_clr, commit, par_err;
  logic [CFG_W*NUM_IOB-1:0] shadow;
  logic [2*NUM_IOB-1:0]     tsmux_d;
  logic [NUM_IOB-1:0]       dorreg_d;

`ifdef IOCFG_PARITY_EN
  assign par_err = ^{CFG_PAR, CFG_DATA};
`else
  logic unused_par;
  assign unused_par = CFG_PAR;
  assign par_err    = 1'b0;
`endif

  always_ff @(posedge IOCLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Handshake: a word transfers on a rising edge where CFG_VALID && CFG_READY.
  // CFG_READY is withheld whenever START/ABORT/RST win the cycle, so a
  // presented word is never silently dropped while READY is high.
  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    wr_en     = 1'b0;
    cnt_clr   = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    commit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CFG_START) begin
          state_d = ST_LOAD;
          cnt_clr = 1'b1;
          err_clr = 1'b1;
        end
      end
      ST_LOAD: begin
        if (CFG_ABORT) begin
          state_d = ST_IDLE;
          err_set = 1'b1;
        end else if (CFG_START) begin
          cnt_clr = 1'b1;
          err_set = 1'b1;
        end else begin
          cfg_ready = (LOAD_CNT < CNT_FULL);
          if (CFG_VALID && cfg_ready) begin
            if (par_err) begin
              state_d = ST_IDLE;
              err_set = 1'b1;
            end else begin
              wr_en = 1'b1;
              if (LOAD_CNT == CNT_LAST) state_d = ST_COMMIT;
            end
          end
        end
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (RST) begin
      cfg_ready = 1'b0;
      wr_en     = 1'b0;
    end
  end

  ioblock_cfg_shadow #(.NUM_IOB(NUM_IOB), .CNT_W(CNT_W)) u_shadow (
    .clk   (IOCLK),
    .rst   (RST),
    .we    (wr_en),
    .waddr (LOAD_CNT),
    .wdata (CFG_DATA),
    .rdata (shadow)
  );

  for (genvar k = 0; k < NUM_IOB; k++) begin : g_map
    assign tsmux_d[2*k +: 2] = shadow[CFG_W*k + CFG_TSMUX_LSB +: CFG_TSMUX_W];
    assign dorreg_d[k]       = shadow[CFG_W*k + CFG_DORREG_BIT];
  end

  always_ff @(posedge IOCLK) begin
    if (RST) begin
      LOAD_CNT   <= '0;
      ERR        <= 1'b0;
      DONE       <= 1'b0;
      TSMUX_OUT  <= '0;
      DORREG_OUT <= '0;
    end else begin
      if (cnt_clr)    LOAD_CNT <= '0;
      else if (wr_en) LOAD_CNT <= LOAD_CNT + CNT_W'(1);
      if (err_set)      ERR <= 1'b1;
      else if (err_clr) ERR <= 1'b0;
      DONE <= commit;
      // The only path to the live buses: all pins in one edge.
      if (commit) begin
        TSMUX_OUT  <= tsmux_d;
        DORREG_OUT <= dorreg_d;
      end
    end
  end

  assign CFG_READY = cfg_ready;
  assign BUSY      = (state_q != ST_IDLE);
  assign CFG_STATE = state_q;

endmodule
